cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
- Shares one combinational unsigned magnitude comparator (a>b / a==b / a<b outputs) between NREQ requesters.
- Round-robin arbitration selects one requester at a time and drives its operand pair onto the comparator.
- Captures the lesser/equal/greater result and returns it on a valid/ready response channel, tagged with the requester ID.
- Sits between the comparator instance and the client blocks that need magnitude comparisons.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, operand width in bits (unsigned)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B, same packing
req_ready  output  NREQ  one-hot accept pulse
cmp_a  output  WIDTH  operand A to shared comparator
cmp_b  output  WIDTH  operand B to shared comparator
cmp_lesser  input  1  comparator a<b
cmp_equal  input  1  comparator a==b
cmp_greater  input  1  comparator a>b
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer ready
rsp_id  output  IDW  ID of the requester being answered
rsp_lesser  output  1  captured a<b
rsp_equal  output  1  captured a==b
rsp_greater  output  1  captured a>b

Behaviour:
- The clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: IDLE, CMP, RESP. Reset value is IDLE.
- Reset values:
  - req_ready=0, cmp_a=0, cmp_b=0, rsp_valid=0, rsp_id=0, all rsp_* result bits=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching from last_grant+1 upward, modulo NREQ.
  - req_ready[g] is combinationally high for that one cycle only.
  - At the clock edge, latch a_reg/b_reg/id_reg from requester g, set last_grant=g, go to CMP.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- CMP:
  - cmp_a=a_reg and cmp_b=b_reg (registered; they are stable for the whole state).
  - At the edge, capture cmp_lesser/equal/greater into the rsp_* registers, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid and all rsp_* outputs hold stable until rsp_valid && rsp_ready.
  - On that handshake edge: rsp_valid=0, result bits cleared to 0, go to IDLE.
  - No new grant is issued in RESP.
- Latency and throughput:
  - Grant in cycle t gives rsp_valid high from cycle t+2.
  - Best-case throughput is one comparison every 3 cycles.
- Handshake rules:
  - A requester holds req_valid and its operands stable until it sees its req_ready.
  - Deasserting req_valid before the grant simply withdraws the request.
  - Operand changes after the accept cycle have no effect.
- rsp_ready while rsp_valid=0 is ignored.
- While rsp_valid=1, exactly one of rsp_lesser/equal/greater is 1. This is the comparator's contract and is checked by assertion.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ grants.
- Wrap-around: if last_grant=NREQ-1, the search starts at 0.
- A single active requester is granted repeatedly.
- Reset asserted mid-operation, in any state: the next edge returns to reset values. The in-flight comparison is discarded and no response is produced.
- req_ready is never asserted while rst=1.

Optional Feature:
- Macro: CMP_SHARE_STATS_EN.
- Defined:
  - Adds output ports `grant_count` (16 bits) and `busy` (1 bit).
  - grant_count increments on each completed response handshake, saturates at 16'hFFFF, and clears on rst.
  - busy=1 whenever the state is not IDLE.
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical in both builds.

Test Plan:
- Reset, then only requester 2 valid with a=4'd9, b=4'd3 -> req_ready=4'b0100 for one cycle; two cycles later rsp_valid=1, rsp_id=2, rsp_greater=1, others 0.
- Requester 0 valid with a=b=4'd7, rsp_ready held 0 for 5 cycles -> response held stable with rsp_equal=1; cleared 1 cycle after rsp_ready=1; no new req_ready during the stall.
- All 4 requesters valid continuously, operands a=i, b=2 -> grant order 0,1,2,3,0; responses in order: less, less, equal, greater; rsp_ready=1 gives a grant every 3 cycles.
- Boundaries: a=4'd0, b=4'd15 -> rsp_lesser=1; a=4'd15, b=4'd0 -> rsp_greater=1.
- rst asserted in the CMP state -> next cycle state is IDLE, rsp_valid stays 0, and the next grant goes to requester 0.
- With CMP_SHARE_STATS_EN defined: 3 completed handshakes -> grant_count=3; busy=1 during CMP/RESP and 0 in IDLE.

Source files
------------

// File: rtl/cmp_share_arbiter_if.sv
// Purpose: request / shared-comparator / response bundle for cmp_share_arbiter.
// Latency: wires only, no storage.
// Backpressure: req_valid/req_ready per requester; rsp_valid/rsp_ready on the response side.
//
// Signals:
//   req_valid[NREQ]     per-requester request valid
//   req_a/req_b         operands, requester i at bits [i*WIDTH +: WIDTH]
//   req_ready[NREQ]     one-hot accept pulse
//   cmp_a/cmp_b         operands presented to the shared comparator
//   cmp_lesser/equal/greater   comparator results
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester being answered
//   rsp_lesser/equal/greater   captured result
// Modports: slave = arbiter side, master = clients + comparator side.
interface cmp_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      cmp_a;
    logic [WIDTH-1:0]      cmp_b;
    logic                  cmp_lesser;
    logic                  cmp_equal;
    logic                  cmp_greater;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_lesser;
    logic                  rsp_equal;
    logic                  rsp_greater;

    modport slave (
        input  req_valid, req_a, req_b, cmp_lesser, cmp_equal, cmp_greater, rsp_ready,
        output req_ready, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_lesser, rsp_equal, rsp_greater
    );

    modport master (
        output req_valid, req_a, req_b, cmp_lesser, cmp_equal, cmp_greater, rsp_ready,
        input  req_ready, cmp_a, cmp_b, rsp_valid, rsp_id, rsp_lesser, rsp_equal, rsp_greater
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Purpose: round-robin share of one external magnitude comparator between NREQ requesters.
// Latency: grant in cycle t -> rsp_valid from cycle t+2; best case one comparison per 3 cycles.
// Backpressure: response holds until rsp_ready; no grant is issued until the response is taken.
//
// Ports: clk, rst (synchronous, active-high), bus (cmp_share_arbiter_if.slave).
// Optional build macro CMP_SHARE_STATS_EN adds grant_count[15:0] (saturating count
// of completed responses) and busy (state is not IDLE).
module cmp_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    cmp_share_arbiter_if.slave bus
`ifdef CMP_SHARE_STATS_EN
    ,
    output logic [15:0]       grant_count,
    output logic              busy
`endif
);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t           state_q;
    state_t           state_d;

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_lesser_q;
    logic             rsp_equal_q;
    logic             rsp_greater_q;

    logic             found_hi;
    logic             found_lo;
    logic [IDW-1:0]   idx_hi;
    logic [IDW-1:0]   idx_lo;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic             take_grant;
    logic             capture;
    logic             handshake;

    // Round-robin search split in two passes: requesters above last_grant
    // win first; otherwise wrap and take the lowest at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && !found_hi && (i > int'(last_grant))) begin
                found_hi = 1'b1;
                idx_hi   = IDW'(i);
            end
            if (bus.req_valid[i] && !found_lo && (i <= int'(last_grant))) begin
                found_lo = 1'b1;
                idx_lo   = IDW'(i);
            end
        end
        grant_found = found_hi || found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_a = bus.req_a[i*WIDTH +: WIDTH];
                sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM next state and control strobes.
    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found && !rst) begin
                    take_grant = 1'b1;
                    state_d    = CMP;
                end
            end
            CMP: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accept pulse is only ever raised in the grant cycle, never under reset.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = take_grant && (IDW'(i) == grant_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant    <= IDW'(NREQ - 1);
            id_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_lesser_q  <= 1'b0;
            rsp_equal_q   <= 1'b0;
            rsp_greater_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_grant) begin
                a_reg      <= sel_a;
                b_reg      <= sel_b;
                id_reg     <= grant_idx;
                last_grant <= grant_idx;
            end
            if (capture) begin
                rsp_valid_q   <= 1'b1;
                rsp_id_q      <= id_reg;
                rsp_lesser_q  <= bus.cmp_lesser;
                rsp_equal_q   <= bus.cmp_equal;
                rsp_greater_q <= bus.cmp_greater;
            end else if (handshake) begin
                rsp_valid_q   <= 1'b0;
                rsp_lesser_q  <= 1'b0;
                rsp_equal_q   <= 1'b0;
                rsp_greater_q <= 1'b0;
            end
        end
    end

    // Operands come straight from registers so the comparator sees
    // stable values for the whole CMP cycle.
    assign bus.cmp_a       = a_reg;
    assign bus.cmp_b       = b_reg;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_lesser  = rsp_lesser_q;
    assign bus.rsp_equal   = rsp_equal_q;
    assign bus.rsp_greater = rsp_greater_q;

    // The comparator must report exactly one relation.
    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
        rsp_valid_q |-> $onehot({rsp_lesser_q, rsp_equal_q, rsp_greater_q}));

`ifdef CMP_SHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count <= '0;
        end else if (handshake && (grant_count != 16'hFFFF)) begin
            grant_count <= grant_count + 16'd1;
        end
    end

    assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Purpose: self-checking bench for cmp_share_arbiter (directed scenarios + random run vs reference model).
// Latency: n/a.
// Backpressure: randomised rsp_ready in the random run; directed stalls elsewhere.
module tb_cmp_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmp_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

`ifdef CMP_SHARE_STATS_EN
    logic [15:0] grant_count;
    logic        busy;
`endif

    cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CMP_SHARE_STATS_EN
        ,
        .grant_count (grant_count),
        .busy        (busy)
`endif
    );

    // The shared comparator itself.
    assign bus.cmp_lesser  = (bus.cmp_a <  bus.cmp_b);
    assign bus.cmp_equal   = (bus.cmp_a == bus.cmp_b);
    assign bus.cmp_greater = (bus.cmp_a >  bus.cmp_b);

    int n_vec = 0;
    int n_err = 0;

    logic             rst_v;
    logic             rdy;
    logic [NREQ-1:0]  vld;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    // One clock cycle: apply the staged inputs just after the rising edge,
    // then return at the falling edge where outputs are sampled.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst           = rst_v;
        bus.req_valid = vld;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
            bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
        bus.rsp_ready = rdy;
        @(negedge clk);
    endtask

    task automatic put(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        vld[i]  = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        vld   = '0;
        rdy   = 1'b0;
        cyc();
        rst_v = 1'b0;
    endtask

    task automatic test_reset();
        rst_v = 1'b1;
        vld   = '1;
        rdy   = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = WIDTH'(i + 1);
            op_b[i] = WIDTH'(i);
        end
        cyc();
        n_vec++;
        if (bus.req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready_first: got %b want 0000", bus.req_ready);
        end
        cyc();
        n_vec++;
        if (bus.req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready_idle: got %b want 0000", bus.req_ready);
        end
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== 6'b0) begin
            n_err++; $display("FAIL reset_rsp: got v=%b id=%0d bits=%b%b%b want all 0",
                bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        n_vec++;
        if ({bus.cmp_a, bus.cmp_b} !== 8'h00) begin
            n_err++; $display("FAIL reset_cmp_ops: got a=%0d b=%0d want 0 0", bus.cmp_a, bus.cmp_b);
        end
        rst_v = 1'b0;
        vld   = '0;
        rdy   = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        put(2, 4'd9, 4'd3);
        cyc();
        n_vec++;
        if (bus.req_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_grant: got %b want 0100", bus.req_ready);
        end
        vld = '0;
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.cmp_a, bus.cmp_b} !== {4'b0000, 1'b0, 4'd9, 4'd3}) begin
            n_err++; $display("FAIL single_cmp_state: got rdy=%b v=%b a=%0d b=%0d want 0000 0 9 3",
                bus.req_ready, bus.rsp_valid, bus.cmp_a, bus.cmp_b);
        end
        cyc();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== {1'b1, 2'd2, 3'b001}) begin
            n_err++; $display("FAIL single_rsp: got v=%b id=%0d lEg=%b%b%b want 1 2 001",
                bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        rdy = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== 4'b0000) begin
            n_err++; $display("FAIL single_clear: got v=%b bits=%b%b%b want 0 000",
                bus.rsp_valid, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        rdy = 1'b0;
    endtask

    // Runs straight after test_single, so the pointer sits at requester 2.
    task automatic test_stall();
        put(0, 4'd7, 4'd7);
        cyc();
        n_vec++;
        if (bus.req_ready !== 4'b0001) begin
            n_err++; $display("FAIL stall_grant: got %b want 0001", bus.req_ready);
        end
        vld = '0;
        put(1, 4'd1, 4'd1);
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_vec++;
            if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater}
                    !== {4'b0000, 1'b1, 2'd0, 3'b010}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b id=%0d lEg=%b%b%b want 0000 1 0 010",
                    k, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
            end
        end
        rdy = 1'b1;
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== {4'b0000, 1'b1}) begin
            n_err++; $display("FAIL stall_hs_cycle: got rdy=%b v=%b want 0000 1", bus.req_ready, bus.rsp_valid);
        end
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== {4'b0010, 1'b0}) begin
            n_err++; $display("FAIL stall_after: got rdy=%b v=%b want 0010 0", bus.req_ready, bus.rsp_valid);
        end
        vld = '0;
        cyc();
        cyc();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== {1'b1, 2'd1, 3'b010}) begin
            n_err++; $display("FAIL stall_next_rsp: got v=%b id=%0d lEg=%b%b%b want 1 1 010",
                bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        cyc();
        rdy = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_res;
        int         g;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            put(i, WIDTH'(i), 4'd2);
        end
        rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            g = n % NREQ;
            exp_res = {op_a[g] < op_b[g], op_a[g] == op_b[g], op_a[g] > op_b[g]};
            cyc();
            n_vec++;
            if (bus.req_ready !== (4'b0001 << g)) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", n, bus.req_ready, 4'b0001 << g);
            end
            cyc();
            n_vec++;
            if ({bus.req_ready, bus.rsp_valid} !== 5'b0) begin
                n_err++; $display("FAIL rr_cmp[%0d]: got rdy=%b v=%b want 0000 0", n, bus.req_ready, bus.rsp_valid);
            end
            if (n == 4) vld = '0;
            cyc();
            n_vec++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== {1'b1, IDW'(g), exp_res}) begin
                n_err++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d lEg=%b%b%b want 1 %0d %b",
                    n, bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater, g, exp_res);
            end
        end
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== 5'b0) begin
            n_err++; $display("FAIL rr_drain: got rdy=%b v=%b want 0000 0", bus.req_ready, bus.rsp_valid);
        end
        rdy = 1'b0;
    endtask

    task automatic test_boundaries();
        do_reset();
        rdy = 1'b1;
        put(3, 4'd0, 4'd15);
        cyc();
        n_vec++;
        if (bus.req_ready !== 4'b1000) begin
            n_err++; $display("FAIL bnd_grant0: got %b want 1000", bus.req_ready);
        end
        vld = '0;
        cyc();
        put(3, 4'd15, 4'd0);
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater}
                !== {4'b0000, 1'b1, 2'd3, 3'b100}) begin
            n_err++; $display("FAIL bnd_0_vs_15: got rdy=%b v=%b id=%0d lEg=%b%b%b want 0000 1 3 100",
                bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== {4'b1000, 1'b0}) begin
            n_err++; $display("FAIL bnd_regrant_wrap: got rdy=%b v=%b want 1000 0", bus.req_ready, bus.rsp_valid);
        end
        vld = '0;
        cyc();
        cyc();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== {1'b1, 2'd3, 3'b001}) begin
            n_err++; $display("FAIL bnd_15_vs_0: got v=%b id=%0d lEg=%b%b%b want 1 3 001",
                bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        cyc();
        rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(1, 4'd5, 4'd5);
        cyc();
        n_vec++;
        if (bus.req_ready !== 4'b0010) begin
            n_err++; $display("FAIL rmid_grant: got %b want 0010", bus.req_ready);
        end
        vld   = '1;
        put(0, 4'd12, 4'd4);
        rst_v = 1'b1;
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== 5'b0) begin
            n_err++; $display("FAIL rmid_in_rst: got rdy=%b v=%b want 0000 0", bus.req_ready, bus.rsp_valid);
        end
        rst_v = 1'b0;
        cyc();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid} !== {4'b0001, 1'b0}) begin
            n_err++; $display("FAIL rmid_after: got rdy=%b v=%b want 0001 0", bus.req_ready, bus.rsp_valid);
        end
        vld = '0;
        rdy = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== {1'b1, 2'd0, 3'b001}) begin
            n_err++; $display("FAIL rmid_rsp: got v=%b id=%0d lEg=%b%b%b want 1 0 001",
                bus.rsp_valid, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater);
        end
        cyc();
        rdy = 1'b0;
    endtask

`ifdef CMP_SHARE_STATS_EN
    task automatic test_stats();
        do_reset();
        rdy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            put(0, WIDTH'(n), 4'd1);
            cyc();
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL stats_busy_idle[%0d]: got %b want 0", n, busy);
            end
            vld = '0;
            cyc();
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL stats_busy_cmp[%0d]: got %b want 1", n, busy);
            end
            cyc();
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL stats_busy_resp[%0d]: got %b want 1", n, busy);
            end
        end
        cyc();
        n_vec++;
        if ({grant_count, busy} !== {16'd3, 1'b0}) begin
            n_err++; $display("FAIL stats_count: got cnt=%0d busy=%b want 3 0", grant_count, busy);
        end
        rdy = 1'b0;
    endtask
`endif

    // Transaction-level reference: round-robin choice by modular search,
    // one outstanding comparison at a time, response visible two cycles
    // after the grant and retired by the ready handshake.
    task automatic test_random();
        int         last_m;
        bit         outstanding;
        int         grant_cyc;
        int         g;
        int         j;
        logic [3:0] exp_ready;
        bit         exp_v;
        logic [IDW-1:0] e_id;
        logic [2:0] e_res;
        do_reset();
        last_m      = NREQ - 1;
        outstanding = 1'b0;
        grant_cyc   = 0;
        e_id        = '0;
        e_res       = '0;
        for (int cycle = 0; cycle < 3000; cycle++) begin
            cyc();
            g = -1;
            exp_ready = '0;
            if (!rst_v && !outstanding) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (last_m + k) % NREQ;
                    if (g < 0 && vld[j]) g = j;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            n_vec++;
            if (bus.req_ready !== exp_ready) begin
                n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cycle, bus.req_ready, exp_ready);
            end
            exp_v = outstanding && (cycle - grant_cyc >= 2);
            n_vec++;
            if (bus.rsp_valid !== exp_v) begin
                n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cycle, bus.rsp_valid, exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if ({bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater} !== {e_id, e_res}) begin
                    n_err++; $display("FAIL rnd_rsp@%0d: got id=%0d lEg=%b%b%b want %0d %b",
                        cycle, bus.rsp_id, bus.rsp_lesser, bus.rsp_equal, bus.rsp_greater, e_id, e_res);
                end
            end
            if (rst_v) begin
                outstanding = 1'b0;
                last_m      = NREQ - 1;
            end else if (g >= 0) begin
                outstanding = 1'b1;
                grant_cyc   = cycle;
                last_m      = g;
                e_id        = IDW'(g);
                e_res       = {op_a[g] < op_b[g], op_a[g] == op_b[g], op_a[g] > op_b[g]};
            end else if (exp_v && rdy) begin
                outstanding = 1'b0;
            end
            // Next-cycle stimulus: pending requesters hold unless they withdraw.
            for (int i = 0; i < NREQ; i++) begin
                if (i == g || !vld[i]) begin
                    vld[i]  = ($urandom_range(0, 99) < 40);
                    op_a[i] = WIDTH'($urandom_range(0, 15));
                    op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : WIDTH'($urandom_range(0, 15));
                end else if ($urandom_range(0, 19) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            rdy   = ($urandom_range(0, 2) != 0);
            rst_v = ($urandom_range(0, 199) == 0);
        end
        rst_v = 1'b0;
        vld   = '0;
        rdy   = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        rst_v         = 1'b1;
        rdy           = 1'b0;
        vld           = '0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single();
        test_stall();
        test_round_robin();
        test_boundaries();
        test_reset_mid();
`ifdef CMP_SHARE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
